uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single AXI-Stream byte input of the UART transmitter between NUM_SRC requesters.
- Sits between the software TX-data register path, hardware message generators, and the UART TX FIFO.
- Grants one source at a time, forwards its bytes until tlast or a burst limit, then re-arbitrates.
- Honours the UART control register's tx_reset as a flush.

Parameters:
NUM_SRC, 4, number of requesting AXI-Stream sources (2..8)
DATA_WIDTH, 8, byte width; matches the UART data width
MAX_BURST, 16, max bytes per grant before forced re-arbitration; 0 = unlimited (tlast only)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  tx_reset from the UART control register; aborts the current grant
s_tvalid_i  in  NUM_SRC  per-source valid
s_tdata_i  in  NUM_SRC*DATA_WIDTH  per-source byte, source k at bits [k*DATA_WIDTH +: DATA_WIDTH]
s_tlast_i  in  NUM_SRC  per-source end of message
s_tready_o  out  NUM_SRC  per-source ready
m_tvalid_o  out  1  byte valid to UART TX FIFO
m_tdata_o  out  DATA_WIDTH  byte to UART TX FIFO
m_tlast_o  out  1  end of message forwarded
m_tready_i  in  1  UART TX FIFO not full
grant_o  out  $clog2(NUM_SRC)  index of the current owner; valid while busy_o
busy_o  out  1  a grant is active

Behaviour:
- Only two states: ARB and XFER.
- Reset (rst_i=1, synchronous):
  - state=ARB, rr_ptr=0, burst_cnt=0, grant=0.
  - busy_o=0, m_tvalid_o=0, s_tready_o=0, m_tdata_o=0, m_tlast_o=0.
  - Reset mid-transfer drops the grant. The partial message is not completed.
- ARB:
  - All s_tready_o=0 and m_tvalid_o=0.
  - If any s_tvalid_i is set, pick the first asserted index starting from rr_ptr and wrapping modulo NUM_SRC.
  - Register that index into grant, set burst_cnt=0, and go to XFER next cycle.
  - Arbitration latency is 1 cycle from valid to grant. The first byte can move in the cycle after the grant is registered.
  - With no requests, stay in ARB.
- XFER (combinational datapath from the granted source):
  - m_tvalid_o = s_tvalid_i[grant] and m_tdata_o = s_tdata_i[grant].
  - s_tready_o[grant] = m_tready_i. Every other s_tready_o = 0.
  - m_tlast_o = s_tlast_i[grant] OR (MAX_BURST!=0 AND burst_cnt==MAX_BURST-1).
- Handshake rules:
  - A beat is transferred when m_tvalid_o & m_tready_i.
  - No data is lost or duplicated.
  - Outputs are stable while m_tvalid_o=1 and m_tready_i=0, provided the source obeys AXIS.
- On each beat, burst_cnt increments.
- End of grant is a beat with s_tlast_i[grant]=1, or (MAX_BURST!=0 and burst_cnt==MAX_BURST-1). On end of grant:
  - rr_ptr = (grant+1) mod NUM_SRC.
  - state = ARB.
- Forced end by burst limit: the source keeps its remaining bytes and competes again in ARB. Its tlast is unaffected.
- Tie priority: a request arriving in the same cycle as the end of a grant is seen in the next ARB cycle. The just-served source has the lowest priority.
- Granted source drops valid mid-message: the grant is held indefinitely. There is no timeout, because the message is packet-locked.
- flush_i=1 in any state:
  - Next cycle state=ARB, burst_cnt=0; rr_ptr is kept.
  - In the flush cycle all s_tready_o=0 and m_tvalid_o=0, so no beat occurs that cycle.
  - While flush_i stays high the block stays in ARB and grants nothing.
- flush_i and rst_i together: rst_i wins.
- busy_o = (state==XFER). grant_o is registered and changes only on the ARB->XFER transition.
- Width rules:
  - burst_cnt width is $clog2(MAX_BURST+1), minimum 1.
  - rr_ptr and grant are $clog2(NUM_SRC) bits. Wrap uses an explicit compare against NUM_SRC-1, so non-power-of-two NUM_SRC is supported.

Test Plan:
- Single source: src1 sends 3 bytes 0x41,0x42,0x43, tlast on 0x43, m_tready=1.
  - Expect grant_o=1 one cycle after valid, 3 output beats in order, m_tlast on 0x43, then busy_o=0.
- Round-robin: all 4 sources each hold a 2-byte message.
  - Expect grant order 0,1,2,3, 8 beats total, with no interleaving inside a message.
  - Then src0 requests again: expect grant 0.
- Burst limit: MAX_BURST=16, src2 sends 20 bytes with tlast on byte 20, src3 also requesting.
  - Expect 16 bytes from src2 with m_tlast on byte 16, then src3's message, then src2's remaining 4 bytes with m_tlast on byte 20.
- Backpressure: toggle m_tready_i randomly during a 10-byte message from src0.
  - Expect m_tdata_o stable while stalled, exactly 10 beats, and byte sequence 0x00..0x09 intact.
- Flush: assert flush_i for 2 cycles after byte 3 of a 6-byte src1 message.
  - Expect no beats while flush_i is high and busy_o=0.
  - Expect re-arbitration afterwards starting at rr_ptr (not advanced).
- Reset mid-transfer: assert rst_i during byte 2 of a src0 message.
  - Expect all outputs at reset values the next cycle and rr_ptr=0.
  - After release with src0 and src3 requesting, expect grant 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin, packet-locked AXIS arbiter feeding the UART TX FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NUM_SRC-1:0]            s_tvalid_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata_i,
  input  logic [NUM_SRC-1:0]            s_tlast_i,
  output logic [NUM_SRC-1:0]            s_tready_o,
  output logic                          m_tvalid_o,
  output logic [DATA_WIDTH-1:0]         m_tdata_o,
  output logic                          m_tlast_o,
  input  logic                          m_tready_i,
  output logic [$clog2(NUM_SRC)-1:0]    grant_o,
  output logic                          busy_o
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [GW-1:0] LAST_SRC   = GW'(NUM_SRC - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam bit            LIMITED    = (MAX_BURST != 0);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;

  logic                  xfer_active;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  burst_hit;
  logic                  beat;
  logic                  end_of_grant;
  logic [GW-1:0]         grant_inc;
  logic [GW-1:0]         cand;
  logic [GW-1:0]         pick_idx;
  logic                  pick_found;

  // Datapath is live only in XFER; flush and reset both block the beat in the same cycle.
  always_comb begin
    xfer_active  = (state_q == ST_XFER) && !flush_i && !rst_i;
    sel_valid    = s_tvalid_i[grant_q];
    sel_last     = s_tlast_i[grant_q];
    sel_data     = s_tdata_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    burst_hit    = LIMITED && (burst_cnt_q == BURST_LAST);
    beat         = xfer_active && sel_valid && m_tready_i;
    end_of_grant = beat && (sel_last || burst_hit);
    grant_inc    = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;

    m_tvalid_o = xfer_active && sel_valid;
    m_tdata_o  = xfer_active ? sel_data : '0;
    m_tlast_o  = xfer_active && (sel_last || burst_hit);
    s_tready_o = xfer_active ? (NUM_SRC'(m_tready_i) << grant_q) : '0;
  end

  // First requester at or after rr_ptr, wrapping by explicit compare so any NUM_SRC works.
  always_comb begin
    cand       = rr_ptr_q;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!pick_found && s_tvalid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == LAST_SRC) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    if (flush_i) begin
      state_d     = ST_ARB;
      burst_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (pick_found) begin
            grant_d     = pick_idx;
            burst_cnt_d = '0;
            state_d     = ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
            if (end_of_grant) begin
              state_d     = ST_ARB;
              rr_ptr_d    = grant_inc;
              burst_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign busy_o  = (state_q == ST_XFER);
  assign grant_o = grant_q;

endmodule

`default_nettype wire
